calc_alu: RTL

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_alu_pkg.sv | 18 +
 rtl/calc_addsub.sv | 31 +++
 rtl/calc_alu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/calc_alu_pkg.sv
// calc_alu shared types: operation encoding and FSM states.
// Imported by calc_alu and calc_addsub.
package calc_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_addsub.sv
// Ripple-carry add/subtract: sum = a + (b ^ {sub}) + sub.
// Signed overflow from the top two carries; raw carry out for unsigned use.
module calc_addsub
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_b;

  assign w_b    = i_b ^ {WIDTH{i_sub}};
  assign w_c[0] = i_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_b[i]) |
                       (w_c[i] & (i_a[i] ^ w_b[i]));
  end

  assign o_cout = w_c[WIDTH];
  assign o_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/calc_alu.sv
// Signed ADD/SUB/MUL unit with valid/ready handshake.
// Define CALC_ALU_SAT_EN to clamp overflowing results instead of wrapping.
module calc_alu
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_phi;
  logic [WIDTH-1:0] r_plo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;
  logic             r_out_valid;

  logic               w_accept;
  logic               w_mul;
  logic               w_last;
  logic               w_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b_in;
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_aovf;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_sprod;
  logic [WIDTH:0]     w_hi;
  logic [WIDTH-1:0]   w_true;
  logic [WIDTH-1:0]   w_res;
  logic               w_fovf;
  logic               w_ferr;

  assign in_ready = (r_state == S_IDLE) |
                    ((r_state == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_mul    = (r_op == OP_MUL);
  assign w_last   = (r_cnt == CW'(WIDTH));
  assign w_neg    = r_a[WIDTH-1] ^ r_b[WIDTH-1];

  // Magnitudes: |most negative| still fits as an unsigned WIDTH value.
  assign w_mag_a    = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_mag_b_in = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // One adder serves ADD/SUB and each multiply accumulate step.
  assign w_add_a = w_mul ? r_phi : r_a;
  assign w_add_b = w_mul ? (r_plo[0] ? w_mag_a : '0) : r_b;

  calc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (r_op == OP_SUB),
    .o_sum (w_sum),
    .o_cout(w_cout),
    .o_ovf (w_aovf)
  );

  assign w_prod  = {r_phi, r_plo};
  assign w_sprod = w_neg ? -w_prod : w_prod;
  assign w_hi    = w_sprod[2*WIDTH-1:WIDTH-1];

  // Select the exact-width result and flags for the captured operation.
  always_comb begin
    w_true = '0;
    w_fovf = 1'b0;
    w_ferr = 1'b0;
    unique case (r_op)
      OP_ADD, OP_SUB: begin
        w_true = w_sum;
        w_fovf = w_aovf;
      end
      OP_MUL: begin
        w_true = w_sprod[WIDTH-1:0];
        w_fovf = !((&w_hi) | (~|w_hi));
      end
      OP_RSV: w_ferr = 1'b1;
    endcase
  end

`ifdef CALC_ALU_SAT_EN
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  logic w_tsign;
  assign w_tsign = w_mul ? w_sprod[2*WIDTH-1]
                         : (w_sum[WIDTH-1] ^ w_aovf);
  assign w_res = w_fovf ? (w_tsign ? MINV : MAXV) : w_true;
`else
  assign w_res = w_true;
`endif

  // FSM: capture on handshake, iterate multiply, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_phi       <= '0;
      r_plo       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= S_BUSY;
      r_op        <= op_e'(op);
      r_a         <= operand_a;
      r_b         <= operand_b;
      r_phi       <= '0;
      r_plo       <= w_mag_b_in;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (w_mul && !w_last) begin
        r_phi <= {w_cout, w_sum[WIDTH-1:1]};
        r_plo <= {w_sum[0], r_plo[WIDTH-1:1]};
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_ovf       <= w_fovf;
        r_zero      <= (w_res == '0);
        r_neg       <= w_res[WIDTH-1];
        r_err       <= w_ferr;
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign err       = r_err;

endmodule
